// File: rtl/ifu.sv
// ifu: instruction fetch unit for the single-cycle NPC core.
// Owns the PC, fetches one instruction at a time over a valid/ready
// instruction-memory interface and holds inst/pc for the core until commit.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   imem_req_valid/ready       fetch request handshake, imem_addr = pc
//   imem_resp_valid/data/err   fetch response, err marks an access fault
//   inst, inst_valid, pc, snpc instruction handed to decode (snpc = pc + 4)
//   commit, pc_src, alu_result core commit and next-PC selection
//   halt                       ebreak: stop after this commit
//   fetch_err                  sticky fetch fault flag
//
// Optional feature: define IFU_ALIGN_CHECK_EN to trap jump targets that are
// not 4-byte aligned (target[1] set) instead of fetching from them.
module ifu #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   input  logic        imem_resp_err,
   output logic [31:0] inst,
   output logic        inst_valid,
   output logic [31:0] pc,
   output logic [31:0] snpc,
   input  logic        commit,
   input  logic        pc_src,
   input  logic [31:0] alu_result,
   input  logic        halt,
   output logic        fetch_err
);

   localparam int unsigned XLEN = 32;

   typedef enum logic [2:0] {
      S_FETCH_IDLE,
      S_FETCH,
      S_WAIT_RESP,
      S_ISSUE,
      S_HALTED,
      S_ERROR
   } state_t;

   state_t            state_q, state_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic [XLEN-1:0]   inst_q, inst_d;
   logic [XLEN-1:0]   target;
   logic [XLEN-1:0]   pc_plus4;
   logic              err_q, err_d;
   logic              req_q;
   logic              ivalid_q;

   // Jump target with bit0 cleared (JALR semantics).
   assign target   = {alu_result[XLEN-1:1], 1'b0};
   assign pc_plus4 = pc_q + XLEN'(4);

   // Next-state and datapath update.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      inst_d  = inst_q;
      err_d   = err_q;
      case (state_q)
         S_FETCH_IDLE: state_d = S_FETCH;
         S_FETCH: begin
            // Responses arriving here are not ours and are dropped.
            if (imem_req_ready) state_d = S_WAIT_RESP;
         end
         S_WAIT_RESP: begin
            if (imem_resp_valid) begin
               if (imem_resp_err) begin
                  err_d   = 1'b1;
                  inst_d  = NOP_INST;
                  state_d = S_ERROR;
               end else begin
                  inst_d  = imem_resp_data;
                  state_d = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            if (commit) begin
               inst_d = NOP_INST;
               if (halt) begin
                  // pc stays on the ebreak for debug.
                  state_d = S_HALTED;
               end else if (!pc_src) begin
                  pc_d    = pc_plus4;
                  state_d = S_FETCH;
               end else begin
                  pc_d    = target;
                  state_d = S_FETCH;
`ifdef IFU_ALIGN_CHECK_EN
                  if (target[1]) begin
                     err_d   = 1'b1;
                     state_d = S_ERROR;
                  end
`endif
               end
            end
         end
         S_HALTED, S_ERROR: state_d = state_q;
         default: state_d = S_FETCH_IDLE;
      endcase
   end

   // State and output registers; valids are decoded from the next state so
   // they line up with the state they describe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_FETCH_IDLE;
         pc_q     <= RESET_PC;
         inst_q   <= NOP_INST;
         err_q    <= 1'b0;
         req_q    <= 1'b0;
         ivalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         inst_q   <= inst_d;
         err_q    <= err_d;
         req_q    <= (state_d == S_FETCH);
         ivalid_q <= (state_d == S_ISSUE);
      end
   end

   assign imem_req_valid = req_q;
   assign imem_addr      = pc_q;
   assign inst           = inst_q;
   assign inst_valid     = ivalid_q;
   assign pc             = pc_q;
   assign snpc           = pc_plus4;
   assign fetch_err      = err_q;

endmodule

// File: tb/tb_ifu.sv
// tb_ifu: self-checking bench for ifu with a behavioural memory and PC model.
module tb_ifu;

   localparam logic [31:0] RPC = 32'h8000_0000;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        imem_resp_err;
   logic [31:0] inst;
   logic        inst_valid;
   logic [31:0] pc;
   logic [31:0] snpc;
   logic        commit;
   logic        pc_src;
   logic [31:0] alu_result;
   logic        halt;
   logic        fetch_err;

   int n_tests = 0;
   int n_fail  = 0;

   ifu dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_addr(imem_addr), .imem_resp_valid(imem_resp_valid),
      .imem_resp_data(imem_resp_data), .imem_resp_err(imem_resp_err),
      .inst(inst), .inst_valid(inst_valid), .pc(pc), .snpc(snpc),
      .commit(commit), .pc_src(pc_src), .alu_result(alu_result),
      .halt(halt), .fetch_err(fetch_err)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic clear_inputs();
      imem_req_ready  = 1'b0;
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
      imem_resp_err   = 1'b0;
      commit          = 1'b0;
      pc_src          = 1'b0;
      alu_result      = 32'h0;
      halt            = 1'b0;
   endtask

   // Pulse reset; returns at the negedge where rst_n is released.
   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      clear_inputs();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Memory model: waits for a request, stalls ready for rdly cycles, returns
   // the response sdly cycles after accept. Starts and ends on a negedge.
   task automatic fetch_txn(input int rdly, input int sdly, input logic [31:0] data,
                            input logic err, input bit noise,
                            output logic [31:0] addr, output int waited,
                            output bit clean, output bit ok);
      ok = 1'b1; clean = 1'b1; waited = 0; addr = 32'hx;
      imem_resp_valid = 1'b0;
      while (!imem_req_valid && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!imem_req_valid) begin
         ok = 1'b0;
         return;
      end
      addr = imem_addr;
      for (int i = 0; i < rdly; i++) begin
         imem_req_ready = 1'b0;
         if (noise) begin
            // Core-side inputs and stray responses are meaningless in FETCH.
            commit = 1'($urandom); halt = 1'($urandom); pc_src = 1'($urandom);
            alu_result = $urandom; imem_resp_valid = 1'($urandom);
            imem_resp_err = 1'($urandom); imem_resp_data = $urandom;
         end
         @(negedge clk);
         if (!imem_req_valid || imem_addr !== addr || inst_valid) clean = 1'b0;
      end
      imem_resp_valid = 1'b0;
      imem_req_ready  = 1'b1;
      @(negedge clk);
      imem_req_ready = 1'b0;
      if (imem_req_valid || inst_valid) clean = 1'b0;
      for (int i = 0; i < sdly; i++) begin
         if (noise) begin
            commit = 1'($urandom); halt = 1'($urandom); pc_src = 1'($urandom);
            alu_result = $urandom;
         end
         @(negedge clk);
         if (imem_req_valid || inst_valid) clean = 1'b0;
      end
      imem_resp_valid = 1'b1;
      imem_resp_data  = data;
      imem_resp_err   = err;
      @(negedge clk);
      imem_resp_valid = 1'b0;
      imem_resp_err   = 1'b0;
      imem_resp_data  = $urandom;
      commit = 1'b0; halt = 1'b0;
   endtask

   task automatic do_commit(input logic src, input logic [31:0] alu, input logic hlt);
      commit = 1'b1; pc_src = src; alu_result = alu; halt = hlt;
      @(negedge clk);
      commit = 1'b0; halt = 1'b0; pc_src = 1'($urandom); alu_result = $urandom;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      clear_inputs();
      #1;
      n_tests++; if (pc !== RPC) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", pc, RPC); end
      n_tests++; if (inst !== NOP) begin n_fail++; $display("FAIL reset_inst: got %h expected %h", inst, NOP); end
      n_tests++; if (snpc !== RPC + 32'd4) begin n_fail++; $display("FAIL reset_snpc: got %h expected %h", snpc, RPC + 32'd4); end
      n_tests++; if ({imem_req_valid, inst_valid, fetch_err} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {imem_req_valid, inst_valid, fetch_err}); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Zero-wait first fetch, then sequential, jump, backpressure and wrap.
   task automatic test_directed();
      logic [31:0] a; int w; bit c, ok;
      n_tests++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL release_req: got %b expected 0", imem_req_valid); end
      fetch_txn(0, 0, 32'h0010_0093, 1'b0, 1'b0, a, w, c, ok);
      n_tests++; if (w !== 1) begin n_fail++; $display("FAIL first_gap: got %0d expected 1", w); end
      n_tests++; if (a !== RPC) begin n_fail++; $display("FAIL first_addr: got %h expected %h", a, RPC); end
      n_tests++; if ({ok, c, inst_valid} !== 3'b111) begin n_fail++; $display("FAIL first_valid: got %b expected 111", {ok, c, inst_valid}); end
      n_tests++; if (inst !== 32'h0010_0093) begin n_fail++; $display("FAIL first_inst: got %h expected %h", inst, 32'h0010_0093); end
      n_tests++; if (snpc !== 32'h8000_0004) begin n_fail++; $display("FAIL first_snpc: got %h expected 80000004", snpc); end

      do_commit(1'b0, 32'hDEAD_BEEF, 1'b0);
      n_tests++; if ({inst_valid, imem_req_valid} !== 2'b01) begin n_fail++; $display("FAIL seq_after_commit: got %b expected 01", {inst_valid, imem_req_valid}); end
      fetch_txn(0, 0, 32'h1111_1111, 1'b0, 1'b0, a, w, c, ok);
      n_tests++; if ({a, w, c, ok} !== {32'h8000_0004, 32'd0, 2'b11}) begin n_fail++; $display("FAIL seq_addr: got %h/%0d/%b%b expected 80000004/0/11", a, w, c, ok); end

      do_commit(1'b1, 32'h8000_0101, 1'b0);
      fetch_txn(0, 1, 32'h2222_2222, 1'b0, 1'b0, a, w, c, ok);
      n_tests++; if ({a, c, ok} !== {32'h8000_0100, 2'b11}) begin n_fail++; $display("FAIL jump_addr: got %h/%b%b expected 80000100/11", a, c, ok); end
      n_tests++; if (inst !== 32'h2222_2222) begin n_fail++; $display("FAIL jump_inst: got %h expected 22222222", inst); end

      do_commit(1'b0, 32'h0, 1'b0);
      fetch_txn(5, 0, 32'h3333_3333, 1'b0, 1'b0, a, w, c, ok);
      n_tests++; if ({a, c, ok} !== {32'h8000_0104, 2'b11}) begin n_fail++; $display("FAIL backpressure: got %h/%b%b expected 80000104/11", a, c, ok); end

      do_commit(1'b1, 32'hFFFF_FFFD, 1'b0);
      fetch_txn(0, 0, 32'h4444_4444, 1'b0, 1'b0, a, w, c, ok);
      n_tests++; if (a !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_pre: got %h expected fffffffc", a); end
      n_tests++; if (snpc !== 32'h0) begin n_fail++; $display("FAIL wrap_snpc: got %h expected 00000000", snpc); end
      do_commit(1'b0, 32'h0, 1'b0);
      fetch_txn(0, 0, 32'h5555_5555, 1'b0, 1'b0, a, w, c, ok);
      n_tests++; if (a !== 32'h0) begin n_fail++; $display("FAIL wrap_addr: got %h expected 00000000", a); end
   endtask

   // Random waits, data, idle cycles and next-PC choices vs. a PC model.
   task automatic test_random();
      logic [31:0] a, d, exp_pc, alu; int w, k; bit c, ok; logic src;
      apply_reset();
      exp_pc = RPC;
      for (int it = 0; it < 40; it++) begin
         d = $urandom;
         fetch_txn(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), d, 1'b0, 1'b1, a, w, c, ok);
         n_tests++; if (a !== exp_pc) begin n_fail++; $display("FAIL rand_addr[%0d]: got %h expected %h", it, a, exp_pc); end
         n_tests++; if ({ok, c, inst_valid} !== 3'b111) begin n_fail++; $display("FAIL rand_proto[%0d]: got %b expected 111", it, {ok, c, inst_valid}); end
         n_tests++; if ({inst, pc, snpc} !== {d, exp_pc, exp_pc + 32'd4}) begin n_fail++; $display("FAIL rand_hold[%0d]: got %h %h %h expected %h %h %h", it, inst, pc, snpc, d, exp_pc, exp_pc + 32'd4); end
         k = int'($urandom_range(0, 2));
         for (int j = 0; j < k; j++) begin
            pc_src = 1'($urandom); alu_result = $urandom; halt = 1'($urandom);
            @(negedge clk);
         end
         halt = 1'b0;
         n_tests++; if ({inst_valid, inst, pc} !== {1'b1, d, exp_pc}) begin n_fail++; $display("FAIL rand_stable[%0d]: got %b %h %h expected 1 %h %h", it, inst_valid, inst, pc, d, exp_pc); end
         src = 1'($urandom);
         alu = $urandom;
`ifdef IFU_ALIGN_CHECK_EN
         alu[1] = 1'b0;
`endif
         do_commit(src, alu, 1'b0);
         exp_pc = src ? (alu & 32'hFFFF_FFFE) : exp_pc + 32'd4;
      end
   endtask

   task automatic test_halt();
      logic [31:0] a; int w, req_cnt, iv_cnt; bit c, ok;
      apply_reset();
      fetch_txn(0, 0, 32'h0000_006F, 1'b0, 1'b0, a, w, c, ok);
      do_commit(1'b1, 32'h8000_0010, 1'b0);
      fetch_txn(0, 0, 32'h0010_0073, 1'b0, 1'b0, a, w, c, ok);
      n_tests++; if (a !== 32'h8000_0010) begin n_fail++; $display("FAIL halt_addr: got %h expected 80000010", a); end
      do_commit(1'b1, 32'h1234_5678, 1'b1);
      req_cnt = 0; iv_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         commit = 1'($urandom); pc_src = 1'($urandom); alu_result = $urandom;
         if (imem_req_valid) req_cnt++;
         if (inst_valid) iv_cnt++;
         @(negedge clk);
      end
      commit = 1'b0;
      n_tests++; if (req_cnt !== 0) begin n_fail++; $display("FAIL halt_req: got %0d requests expected 0", req_cnt); end
      n_tests++; if (iv_cnt !== 0) begin n_fail++; $display("FAIL halt_inst_valid: got %0d cycles expected 0", iv_cnt); end
      n_tests++; if (pc !== 32'h8000_0010) begin n_fail++; $display("FAIL halt_pc: got %h expected 80000010", pc); end
   endtask

   task automatic test_misaligned();
      logic [31:0] a; int w, req_cnt; bit c, ok;
      apply_reset();
      fetch_txn(0, 0, 32'h0000_0067, 1'b0, 1'b0, a, w, c, ok);
      do_commit(1'b1, 32'h8000_0103, 1'b0);
`ifdef IFU_ALIGN_CHECK_EN
      req_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         if (imem_req_valid) req_cnt++;
         @(negedge clk);
      end
      n_tests++; if ({fetch_err, inst_valid} !== 2'b10) begin n_fail++; $display("FAIL align_err: got %b expected 10", {fetch_err, inst_valid}); end
      n_tests++; if (pc !== 32'h8000_0102) begin n_fail++; $display("FAIL align_pc: got %h expected 80000102", pc); end
      n_tests++; if (req_cnt !== 0) begin n_fail++; $display("FAIL align_req: got %0d expected 0", req_cnt); end
`else
      req_cnt = 0;
      fetch_txn(0, 0, 32'h0000_0013, 1'b0, 1'b0, a, w, c, ok);
      n_tests++; if ({a, ok, fetch_err} !== {32'h8000_0102, 2'b10}) begin n_fail++; $display("FAIL misaligned_fetch: got %h/%b%b expected 80000102/10", a, ok, fetch_err); end
      n_tests++; if (req_cnt !== 0) begin n_fail++; $display("FAIL misaligned_cnt: got %0d expected 0", req_cnt); end
`endif
   endtask

   task automatic test_error();
      logic [31:0] a; int w, req_cnt; bit c, ok;
      apply_reset();
      fetch_txn(1, 1, 32'hCAFE_F00D, 1'b1, 1'b0, a, w, c, ok);
      n_tests++; if ({fetch_err, inst_valid} !== 2'b10) begin n_fail++; $display("FAIL err_flags: got %b expected 10", {fetch_err, inst_valid}); end
      n_tests++; if (inst !== NOP) begin n_fail++; $display("FAIL err_inst: got %h expected %h", inst, NOP); end
      req_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         commit = 1'b1; pc_src = 1'($urandom);
         if (imem_req_valid) req_cnt++;
         @(negedge clk);
      end
      commit = 1'b0;
      n_tests++; if ({req_cnt, fetch_err} !== {32'd0, 1'b1}) begin n_fail++; $display("FAIL err_sticky: got %0d/%b expected 0/1", req_cnt, fetch_err); end
      apply_reset();
      n_tests++; if ({fetch_err, pc} !== {1'b0, RPC}) begin n_fail++; $display("FAIL err_recover: got %b/%h expected 0/%h", fetch_err, pc, RPC); end
   endtask

   // Reset asserted while a response is pending aborts the transaction.
   task automatic test_reset_mid();
      logic [31:0] a; int w; bit c, ok;
      apply_reset();
      fetch_txn(0, 0, 32'h0000_1111, 1'b0, 1'b0, a, w, c, ok);
      do_commit(1'b1, 32'h8000_0400, 1'b0);
      imem_req_ready = 1'b1;
      @(negedge clk);
      imem_req_ready = 1'b0;
      imem_resp_valid = 1'b1; imem_resp_data = 32'hBAD0_BAD0;
      #2 rst_n = 1'b0;
      #1;
      n_tests++; if ({imem_req_valid, inst_valid, pc} !== {2'b00, RPC}) begin n_fail++; $display("FAIL mid_reset: got %b%b/%h expected 00/%h", imem_req_valid, inst_valid, pc, RPC); end
      @(negedge clk);
      imem_resp_valid = 1'b0;
      rst_n = 1'b1;
      fetch_txn(0, 2, 32'h0000_2222, 1'b0, 1'b0, a, w, c, ok);
      n_tests++; if ({a, inst, c, ok} !== {RPC, 32'h0000_2222, 2'b11}) begin n_fail++; $display("FAIL mid_refetch: got %h/%h/%b%b expected %h/00002222/11", a, inst, c, ok, RPC); end
   endtask

   initial begin
      rst_n = 1'b1;
      clear_inputs();
      test_reset();
      test_directed();
      test_random();
      test_halt();
      test_misaligned();
      test_error();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
